k12a_fetch_seq: RTL
===================

# k12a_fetch_seq

Instruction-fetch sequencer for the k12a CPU. Walks a Moore state machine that:
- Reads the two instruction bytes from memory at PC into the instruction high/low registers.
- Optionally fetches an indirect operand from page 0x80 addressed by the low byte.
- Hands off to the execute stage and waits for it to finish.

It drives the store and address-load strobes of the instruction register block, the PC increment, and the memory read request.

## Interface

Parameters:
- none

Ports:
- cpu_clock  in  1  CPU clock; all state changes on rising edge.
- reset  in  1  Synchronous, active-high reset, sampled on rising cpu_clock.
- run  in  1  1 = fetch permitted; 0 = stop at next instruction boundary.
- mem_ready  in  1  Memory completes current read this cycle (used only with K12A_FETCH_WAIT_EN).
- needs_operand  in  1  Decode flag, valid in DECODE: instruction needs indirect operand at {8'h80, inst_low}.
- exec_done  in  1  Execute stage finished current instruction.
- mem_read  out  1  Memory read request.
- pc_addr_load  out  1  Drive PC onto addr_bus.
- pc_inc  out  1  Increment PC at end of cycle.
- inst_high_store  out  1  Capture data_bus into instruction high byte.
- inst_low_store  out  1  Capture data_bus into instruction low byte.
- inst_addr_load  out  1  Drive {8'h80, inst_low} onto addr_bus.
- operand_store  out  1  Capture data_bus into operand latch.
- exec_start  out  1  One-cycle pulse starting execute.
- busy  out  1  State != IDLE.
- state  out  3  Current fetch_state_t encoding, for debug.

## Operation

States and encodings:
- IDLE = 0
- FETCH_HI = 1
- FETCH_LO = 2
- DECODE = 3
- OPERAND = 4
- EXEC = 5

Transitions:
- IDLE → FETCH_HI when run=1; otherwise stay in IDLE.
- FETCH_HI → FETCH_LO on memory completion.
- FETCH_LO → DECODE on memory completion.
- DECODE → OPERAND if needs_operand=1; otherwise → EXEC. exec_start is pulsed on the DECODE → EXEC edge.
- OPERAND → EXEC on memory completion; exec_start is pulsed on that edge.
- EXEC stays in EXEC until exec_done=1. Then → FETCH_HI if run=1, otherwise → IDLE.

Outputs are purely state-decoded, except for the qualification by "done" below:
- FETCH_HI: mem_read=1, pc_addr_load=1; inst_high_store and pc_inc are asserted only when done.
- FETCH_LO: same as FETCH_HI, but with inst_low_store.
- OPERAND: mem_read=1, inst_addr_load=1; operand_store is asserted only when done. PC is not incremented.
- "done" = 1 without the wait option; = mem_ready with it.

Rules:
- pc_addr_load and inst_addr_load are never asserted together.
- run=0 does not abort an instruction in flight. It is honoured only in IDLE and at exec_done.
- Reset mid-fetch or mid-exec returns to IDLE next edge. There are no partial store or pc_inc pulses in the reset cycle.
- Reset state: state=IDLE, and every output is 0.

## Timing

- Zero-wait fetch without operand, run held high:
  - FETCH_HI, FETCH_LO, DECODE, EXEC: 4 cycles minimum per instruction.
  - exec_start asserts in the cycle after DECODE (the first EXEC cycle).
- With operand: 5 cycles minimum.
- Each memory-state wait cycle (mem_ready=0) adds 1 cycle. Strobes stay 0 during wait cycles.
- exec_done arriving in the first EXEC cycle is legal: FETCH_HI follows on the next cycle.
- exec_start is exactly one cycle wide per instruction.

## Configuration

- K12A_FETCH_WAIT_EN defined:
  - FETCH_HI, FETCH_LO and OPERAND hold until mem_ready=1.
  - mem_read stays asserted throughout the wait.
- K12A_FETCH_WAIT_EN undefined:
  - mem_ready is ignored; every memory state lasts exactly one cycle.
  - The port remains present, unconnected internally.

## Structure

- k12a_pkg holds:
  - fetch_state_t enum (3 bits, encodings above).
  - K12A_OPERAND_PAGE = 8'h80 constant, shared with the instruction register block.
- Single module with one state register, next-state logic and output decode. No sub-module is needed.

## Test plan

- Reset mid-fetch:
  - Stimulus: reset=1 for 2 cycles while in FETCH_LO.
  - Expected: state=0 and all outputs 0 on the next edge; no inst_low_store pulse.
- Zero-wait instruction, no operand (run=1, needs_operand=0, exec_done=1 in first EXEC cycle):
  - state sequence 1,2,3,5,1.
  - pc_inc high in exactly 2 of every 4 cycles.
- Operand path (needs_operand=1):
  - state sequence 1,2,3,4,5.
  - inst_addr_load and operand_store high only in state 4.
  - pc_inc low in state 4.
- K12A_FETCH_WAIT_EN (mem_ready=0 for 3 cycles in FETCH_HI):
  - state holds at 1 for 4 cycles, with mem_read=1 throughout.
  - inst_high_store and pc_inc pulse once, in the mem_ready=1 cycle.
- run deasserted during EXEC with exec_done after 5 cycles:
  - state goes 5 → 0.
  - busy drops; no further mem_read.
- Back-to-back instructions:
  - exactly one exec_start per instruction over 10 instructions.
  - pc_addr_load and inst_addr_load never simultaneously high.

Source files
------------

// File: rtl/k12a_pkg.sv
// k12a_pkg: shared types and constants for the k12a fetch path.
//   fetch_state_t     - fetch sequencer state encoding (also exported on the
//                       sequencer's debug 'state' port).
//   K12A_OPERAND_PAGE - high address byte of the indirect operand page; the
//                       instruction register block forms {page, inst_low}.
package k12a_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_HI = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_DECODE   = 3'd3,
    ST_OPERAND  = 3'd4,
    ST_EXEC     = 3'd5
  } fetch_state_t;

  localparam logic [7:0] K12A_OPERAND_PAGE = 8'h80;

endpackage

// File: rtl/k12a_fetch_seq.sv
// k12a_fetch_seq: instruction-fetch sequencer for the k12a CPU.
// Reads instruction high/low bytes at PC, optionally fetches an indirect
// operand from {K12A_OPERAND_PAGE, inst_low}, then starts execute and waits
// for it to finish.
//
// Ports:
//   cpu_clock, reset     - clock, synchronous active-high reset
//   run                  - fetch permitted (honoured in IDLE and at exec_done)
//   mem_ready            - memory read completes this cycle (wait build only)
//   needs_operand        - decode flag, sampled in DECODE
//   exec_done            - execute stage finished
//   mem_read             - memory read request
//   pc_addr_load         - drive PC onto address bus
//   pc_inc               - increment PC at end of cycle
//   inst_high_store/low  - capture data bus into instruction high/low byte
//   inst_addr_load       - drive {page, inst_low} onto address bus
//   operand_store        - capture data bus into operand latch
//   exec_start           - one-cycle execute start pulse
//   busy                 - sequencer not idle
//   state                - current fetch_state_t encoding (debug)
//
// Build option: K12A_FETCH_WAIT_EN - memory states hold until mem_ready=1.
// Without it mem_ready is ignored and every memory state lasts one cycle.
module k12a_fetch_seq
  import k12a_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       run,
  input  logic       mem_ready,
  input  logic       needs_operand,
  input  logic       exec_done,
  output logic       mem_read,
  output logic       pc_addr_load,
  output logic       pc_inc,
  output logic       inst_high_store,
  output logic       inst_low_store,
  output logic       inst_addr_load,
  output logic       operand_store,
  output logic       exec_start,
  output logic       busy,
  output logic [2:0] state
);

  fetch_state_t state_q, state_d;
  logic         mem_read_q, pc_addr_load_q, inst_addr_load_q;
  logic         busy_q, exec_start_q;
  logic         done;
  logic         strobe_ok;

`ifdef K12A_FETCH_WAIT_EN
  assign done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (run)       state_d = ST_FETCH_HI;
      ST_FETCH_HI: if (done)      state_d = ST_FETCH_LO;
      ST_FETCH_LO: if (done)      state_d = ST_DECODE;
      ST_DECODE:   state_d = needs_operand ? ST_OPERAND : ST_EXEC;
      ST_OPERAND:  if (done)      state_d = ST_EXEC;
      ST_EXEC:     if (exec_done) state_d = run ? ST_FETCH_HI : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Level outputs are registered by decoding the next state, so they line up
  // with state_q without a combinational decode after the register.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      mem_read_q       <= 1'b0;
      pc_addr_load_q   <= 1'b0;
      inst_addr_load_q <= 1'b0;
      busy_q           <= 1'b0;
      exec_start_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_read_q       <= (state_d == ST_FETCH_HI) || (state_d == ST_FETCH_LO) ||
                          (state_d == ST_OPERAND);
      pc_addr_load_q   <= (state_d == ST_FETCH_HI) || (state_d == ST_FETCH_LO);
      inst_addr_load_q <= (state_d == ST_OPERAND);
      busy_q           <= (state_d != ST_IDLE);
      exec_start_q     <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
    end
  end

  // Capture strobes fire only in the completing cycle of a memory state and
  // are suppressed while reset is asserted, so a reset never leaves a partial
  // store or PC increment behind.
  assign strobe_ok       = done & ~reset;
  assign inst_high_store = (state_q == ST_FETCH_HI) & strobe_ok;
  assign inst_low_store  = (state_q == ST_FETCH_LO) & strobe_ok;
  assign pc_inc          = ((state_q == ST_FETCH_HI) | (state_q == ST_FETCH_LO)) & strobe_ok;
  assign operand_store   = (state_q == ST_OPERAND) & strobe_ok;

  assign mem_read       = mem_read_q;
  assign pc_addr_load   = pc_addr_load_q;
  assign inst_addr_load = inst_addr_load_q;
  assign busy           = busy_q;
  assign exec_start     = exec_start_q;
  assign state          = state_q;

endmodule
